cell_painter: RTL and testbench

CELL_PAINTER -- requirements
Module: cell_painter

---
 rtl/cell_paint_pkg.sv | 33 +++
 rtl/cell_fifo.sv | 77 +++++++
 rtl/cell_painter.sv | 210 +++++++++++++++++++++
 tb/tb_cell_painter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_paint_pkg.sv
// -----------------------------------------------------------------------------
// cell_paint_pkg
// Shared constants and types for the cell painter: grid geometry defaults,
// the VGA screen limits the painter must stay within, the two life colours,
// the painter FSM encoding and the packed layout of one queued cell update.
// -----------------------------------------------------------------------------
package cell_paint_pkg;

  localparam int CELL_SIZE = 4;
  localparam int GRID_W    = 40;
  localparam int GRID_H    = 30;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;

  localparam logic [2:0] COLOUR_ALIVE = 3'b111;
  localparam logic [2:0] COLOUR_DEAD  = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // One queued update: column, row and colour of a cell.
  typedef struct packed {
    logic [7:0] col;
    logic [7:0] row;
    logic [2:0] colour;
  } cell_upd_t;

  localparam int UPD_W = $bits(cell_upd_t);

endpackage

// File: rtl/cell_fifo.sv
// -----------------------------------------------------------------------------
// cell_fifo
// Synchronous show-ahead FIFO holding pending cell updates.
//   clock    : clock
//   reset_n  : synchronous active-low reset (empties the queue)
//   push_i   : write wdata_i (ignored when full)
//   pop_i    : drop the head entry (ignored when empty)
//   flush_i  : discard every entry; has priority over push/pop
//   wdata_i  : entry to write
//   rdata_o  : current head entry, valid whenever empty_o is 0
//   full_o   : no free slot
//   empty_o  : no entry stored
// -----------------------------------------------------------------------------
module cell_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("cell_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // slots hold valid data, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cell_painter.sv
// -----------------------------------------------------------------------------
// cell_painter
// Turns cell updates (column, row, colour) into a stream of VGA pixel writes.
// Each accepted update is queued, then painted as a CELL_SIZE x CELL_SIZE
// square, one pixel per cycle, x fastest. A clear request blanks the whole
// grid area after the cell in progress completes and discards queued updates.
//   clock      : clock
//   reset_n    : synchronous active-low reset
//   in_valid   : update offered;  in_ready : update taken this cycle
//   in_col/in_row/in_colour : update contents
//   clear      : one-cycle request to blank the screen
//   out_x/out_y/out_colour/plot : VGA write port
//   busy       : painting, clearing, clear pending or queue non-empty
//   drop_err   : sticky, an out-of-range update was discarded
// -----------------------------------------------------------------------------
module cell_painter #(
  parameter int CELL_SIZE  = cell_paint_pkg::CELL_SIZE,
  parameter int GRID_W     = cell_paint_pkg::GRID_W,
  parameter int GRID_H     = cell_paint_pkg::GRID_H,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_col,
  input  logic [7:0] in_row,
  input  logic [2:0] in_colour,
  input  logic       clear,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [2:0] out_colour,
  output logic       plot,
  output logic       busy,
  output logic       drop_err
);

  import cell_paint_pkg::*;

  if (GRID_W * CELL_SIZE > SCREEN_W || GRID_H * CELL_SIZE > SCREEN_H) begin : g_bad_geom
    $error("cell_painter: grid does not fit the 160x120 screen");
  end

  // Every index quantity lives in 8 bits; the geometry check above keeps
  // all products and sums inside that range.
  localparam logic [7:0] CS8    = 8'(CELL_SIZE);
  localparam logic [7:0] CS_M1  = 8'(CELL_SIZE - 1);
  localparam logic [7:0] GW8    = 8'(GRID_W);
  localparam logic [7:0] GH8    = 8'(GRID_H);
  localparam logic [7:0] X_LAST = 8'(GRID_W * CELL_SIZE - 1);
  localparam logic [7:0] Y_LAST = 8'(GRID_H * CELL_SIZE - 1);

  state_e     state_q, state_d;
  logic       clear_pending_q, clear_pending_d;
  logic       drop_err_q, drop_err_d;
  logic [7:0] base_x_q, base_x_d;   // top-left pixel of the cell being painted
  logic [7:0] base_y_q, base_y_d;
  logic [7:0] dx_q, dx_d;
  logic [7:0] dy_q, dy_d;
  logic [7:0] out_x_q, out_x_d;
  logic [7:0] out_y_q, out_y_d;
  logic [2:0] out_colour_q, out_colour_d;
  logic       plot_q, plot_d;

  cell_upd_t  in_upd, head;
  logic       fifo_full, fifo_empty;
  logic       accept, in_range, push, pop, flush, seq_done;

  assign in_ready = reset_n & ~fifo_full & ~clear_pending_q & (state_q != CLEAR);
  assign accept   = in_valid & in_ready;
  assign in_range = (in_col < GW8) && (in_row < GH8);
  assign push     = accept & in_range;
  assign in_upd   = '{col: in_col, row: in_row, colour: in_colour};

  cell_fifo #(
    .WIDTH (UPD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (in_upd),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    plot_d       = plot_q;
    pop          = 1'b0;
    flush        = 1'b0;
    seq_done     = 1'b0;

    case (state_q)
      IDLE: seq_done = 1'b1;

      PAINT: begin
        if (dx_q == CS_M1 && dy_q == CS_M1) begin
          seq_done = 1'b1;
        end else begin
          if (dx_q == CS_M1) begin
            dx_d = '0;
            dy_d = dy_q + 8'd1;
          end else begin
            dx_d = dx_q + 8'd1;
          end
          out_x_d = base_x_q + dx_d;
          out_y_d = base_y_q + dy_d;
        end
      end

      CLEAR: begin
        // The output registers double as the sweep counters.
        if (out_x_q == X_LAST && out_y_q == Y_LAST) begin
          seq_done = 1'b1;
        end else if (out_x_q == X_LAST) begin
          out_x_d = '0;
          out_y_d = out_y_q + 8'd1;
        end else begin
          out_x_d = out_x_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Shared hand-off point: idle cycle, last pixel of a cell, or last pixel
    // of a clear. A pending clear wins over queued cells and discards them;
    // otherwise the next cell starts on this edge with no idle bubble.
    if (seq_done) begin
      if (clear_pending_q) begin
        state_d      = CLEAR;
        flush        = 1'b1;
        out_x_d      = '0;
        out_y_d      = '0;
        out_colour_d = COLOUR_DEAD;
        plot_d       = 1'b1;
      end else if (!fifo_empty) begin
        state_d      = PAINT;
        pop          = 1'b1;
        base_x_d     = head.col * CS8;
        base_y_d     = head.row * CS8;
        dx_d         = '0;
        dy_d         = '0;
        out_x_d      = base_x_d;
        out_y_d      = base_y_d;
        out_colour_d = head.colour;
        plot_d       = 1'b1;
      end else begin
        state_d = IDLE;
        plot_d  = 1'b0;
      end
    end

    // A clear arriving on the very edge a clear starts is kept for one more
    // full clear rather than being absorbed by the current one.
    clear_pending_d = clear | (clear_pending_q & ~flush);
    drop_err_d      = drop_err_q | (accept & ~in_range);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      clear_pending_q <= 1'b0;
      drop_err_q      <= 1'b0;
      base_x_q        <= '0;
      base_y_q        <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      out_x_q         <= '0;
      out_y_q         <= '0;
      out_colour_q    <= '0;
      plot_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      drop_err_q      <= drop_err_d;
      base_x_q        <= base_x_d;
      base_y_q        <= base_y_d;
      dx_q            <= dx_d;
      dy_q            <= dy_d;
      out_x_q         <= out_x_d;
      out_y_q         <= out_y_d;
      out_colour_q    <= out_colour_d;
      plot_q          <= plot_d;
    end
  end

  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign plot       = plot_q;
  assign busy       = (state_q != IDLE) | clear_pending_q | ~fifo_empty;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_cell_painter.sv
// -----------------------------------------------------------------------------
// tb_cell_painter
// Self-checking bench for cell_painter. Expected pixel writes are queued as
// stimulus is driven; a monitor pops one per plot cycle and compares it.
// -----------------------------------------------------------------------------
module tb_cell_painter;

  localparam int CS = 4;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_col;
  logic [7:0] in_row;
  logic [2:0] in_colour;
  logic       clear;
  logic [7:0] out_x;
  logic [7:0] out_y;
  logic [2:0] out_colour;
  logic       plot;
  logic       busy;
  logic       drop_err;

  cell_painter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_col     (in_col),
    .in_row     (in_row),
    .in_colour  (in_colour),
    .clear      (clear),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .plot       (plot),
    .busy       (busy),
    .drop_err   (drop_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [18:0] sb[$];     // expected {x, y, colour} in plot order
  logic [18:0] exp_pix;
  int          run_len  = 0;
  int          last_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor: compare every plotted pixel against the scoreboard and keep
  // track of how long each unbroken run of plot cycles was.
  always @(negedge clock) begin
    if (plot) begin
      run_len++;
      if (sb.size() == 0) begin
        check("extra_plot", 32'(plot), 32'd0);
      end else begin
        exp_pix = sb.pop_front();
        check("pixel", {13'd0, out_x, out_y, out_colour}, {13'd0, exp_pix});
      end
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  task automatic expect_cell(input logic [7:0] col, input logic [7:0] row, input logic [2:0] colour);
    logic [7:0] bx, by;
    bx = 8'(col * CS);
    by = 8'(row * CS);
    for (int dy = 0; dy < CS; dy++)
      for (int dx = 0; dx < CS; dx++)
        sb.push_back({8'(bx + 8'(dx)), 8'(by + 8'(dy)), colour});
  endtask

  task automatic expect_clear();
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        sb.push_back({8'(x), 8'(y), 3'b000});
  endtask

  // Offer one update and hold it until taken. Starts and ends at a negedge.
  task automatic push_cell(input logic [7:0] col, input logic [7:0] row,
                           input logic [2:0] colour, input bit paint, output bit ok);
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_col    = col;
    in_row    = row;
    in_colour = colour;
    for (int i = 0; i < 400 && !ok; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        if (paint) expect_cell(col, row, colour);
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      #1;
      if (!busy && !plot) done = 1'b1;
    end
    if (!done) check("idle_timeout_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_run(input int target, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      #1;
      if (run_len == target) hit = 1'b1;
    end
    if (!hit) check(tag, 32'(run_len), 32'(target));
  endtask

  bit ok;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_col    = '0;
    in_row    = '0;
    in_colour = '0;
    clear     = 1'b0;

    // Reset state.
    repeat (3) @(negedge clock);
    #1;
    check("rst_plot",     32'(plot),       32'd0);
    check("rst_x",        32'(out_x),      32'd0);
    check("rst_y",        32'(out_y),      32'd0);
    check("rst_colour",   32'(out_colour), 32'd0);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_drop_err", 32'(drop_err),   32'd0);
    check("rst_ready",    32'(in_ready),   32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clock);

    // Single cell: plot rises one cycle after the acceptance cycle.
    push_cell(8'd2, 8'd3, 3'd7, 1'b1, ok);
    check("s1_accept", 32'(ok), 32'd1);
    check("s1_lat_first", 32'(plot), 32'd0);
    @(negedge clock);
    #1;
    check("s1_lat_second", 32'(plot), 32'd1);
    wait_idle(100);
    check("s1_run_len", 32'(last_run), 32'd16);
    check("s1_sb_empty", 32'(sb.size()), 32'd0);

    // Nine back-to-back updates: queue fills, painting is gap-free.
    for (int i = 0; i < 9; i++) begin
      push_cell(8'(i * 4 + 1), 8'(i + 2), 3'(i % 7 + 1), 1'b1, ok);
      check("s2_accept", 32'(ok), 32'd1);
    end
    #1;
    check("s2_ready_full", 32'(in_ready), 32'd0);
    check("s2_busy", 32'(busy), 32'd1);
    wait_idle(400);
    check("s2_run_len", 32'(last_run), 32'd144);
    check("s2_sb_empty", 32'(sb.size()), 32'd0);

    // Out-of-range updates complete the handshake and are discarded.
    push_cell(8'd40, 8'd0, 3'd7, 1'b0, ok);
    check("s3_accept_col", 32'(ok), 32'd1);
    #1;
    check("s3_drop_err", 32'(drop_err), 32'd1);
    check("s3_not_busy", 32'(busy), 32'd0);
    @(negedge clock);
    push_cell(8'd0, 8'd30, 3'd7, 1'b0, ok);
    check("s3_accept_row", 32'(ok), 32'd1);
    push_cell(8'd39, 8'd29, 3'd7, 1'b1, ok);
    check("s3_accept_edge", 32'(ok), 32'd1);
    wait_idle(100);
    check("s3_drop_sticky", 32'(drop_err), 32'd1);
    check("s3_sb_empty", 32'(sb.size()), 32'd0);

    // Clear during the 5th pixel with three updates queued.
    push_cell(8'd3, 8'd4, 3'd7, 1'b1, ok);
    push_cell(8'd10, 8'd10, 3'd7, 1'b0, ok);
    push_cell(8'd11, 8'd10, 3'd5, 1'b0, ok);
    push_cell(8'd12, 8'd10, 3'd3, 1'b0, ok);
    check("s4_accept", 32'(ok), 32'd1);
    wait_run(5, "s4_reach_pixel5");
    clear = 1'b1;
    expect_clear();
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("s4_ready_pending", 32'(in_ready), 32'd0);
    check("s4_plot_continues", 32'(plot), 32'd1);
    wait_idle(25000);
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_sb_empty", 32'(sb.size()), 32'd0);

    // Reset at pixel 7 of a cell aborts immediately.
    push_cell(8'd6, 8'd7, 3'd5, 1'b1, ok);
    wait_run(7, "s5_reach_pixel7");
    reset_n = 1'b0;
    @(negedge clock);
    #1;
    check("s5_plot",     32'(plot),       32'd0);
    check("s5_x",        32'(out_x),      32'd0);
    check("s5_y",        32'(out_y),      32'd0);
    check("s5_colour",   32'(out_colour), 32'd0);
    check("s5_drop_err", 32'(drop_err),   32'd0);
    check("s5_ready",    32'(in_ready),   32'd0);
    check("s5_run_len",  32'(last_run),   32'd7);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    check("s5_busy_after", 32'(busy), 32'd0);
    check("s5_ready_after", 32'(in_ready), 32'd1);
    @(negedge clock);

    // Two clear pulses 100 cycles apart: two full back-to-back clears.
    clear = 1'b1;
    expect_clear();
    @(negedge clock);
    clear = 1'b0;
    repeat (99) @(negedge clock);
    clear = 1'b1;
    expect_clear();
    @(negedge clock);
    clear = 1'b0;
    wait_idle(45000);
    check("s6_run_len", 32'(last_run), 32'd38400);
    check("s6_sb_empty", 32'(sb.size()), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
